// File: rtl/pi_bus_xfer_pkg.sv
// Shared constants and state encoding for the PI-to-RAM bus transfer block.
package pi_bus_xfer_pkg;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_ACCESS    = 2'd2,
        ST_DONE      = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/pi_bus_xfer_if.sv
// Request/complete handshake between the SPI-domain decoder and the bus transfer block.
interface pi_bus_xfer_if;
    import pi_bus_xfer_pkg::*;

    logic              pi_pending;
    logic [ADDR_W-1:0] pi_addr;
    logic [DATA_W-1:0] pi_data_in;
    logic              pi_rw_b;
    logic              pi_done;
    logic [DATA_W-1:0] pi_rd_data;

    modport master (
        output pi_pending, pi_addr, pi_data_in, pi_rw_b,
        input  pi_done, pi_rd_data
    );

    modport slave (
        input  pi_pending, pi_addr, pi_data_in, pi_rw_b,
        output pi_done, pi_rd_data
    );

endinterface

// File: rtl/pi_bus_xfer_sync2.sv
// Two-flop synchronizer for a single-bit level crossing into the clk domain.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pi_bus_xfer.sv
// Arbitrated single-byte RAM access on behalf of the SPI-domain command decoder.
module pi_bus_xfer
    import pi_bus_xfer_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    pi_bus_xfer_if.slave      pi,
    input  logic              slot_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              bus_busy
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    logic pend_s;

    sync2 #(.RESET_VAL(1'b0)) u_pend_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pi.pi_pending),
        .q     (pend_s)
    );

    xfer_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;
    logic              ram_oe_n_q, ram_oe_n_d;
    logic              ram_we_n_q, ram_we_n_d;
    logic              bus_busy_q, bus_busy_d;
    logic              pi_done_q, pi_done_d;
    logic              in_access_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            rw_q          <= 1'b1;
            rd_data_q     <= '0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            ram_oe_n_q    <= 1'b1;
            ram_we_n_q    <= 1'b1;
            bus_busy_q    <= 1'b0;
            pi_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            rw_q          <= rw_d;
            rd_data_q     <= rd_data_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_oe_n_q    <= ram_oe_n_d;
            ram_we_n_q    <= ram_we_n_d;
            bus_busy_q    <= bus_busy_d;
            pi_done_q     <= pi_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rw_d      = rw_q;
        rd_data_d = rd_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pend_s) begin
                    state_d = ST_WAIT_SLOT;
                    addr_d  = pi.pi_addr;
                    data_d  = pi.pi_data_in;
                    rw_d    = pi.pi_rw_b;
                end
            end
            ST_WAIT_SLOT: begin
                if (slot_en) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (rw_q) begin
                        rd_data_d = ram_rd_data;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (!pend_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are registered from the next state so they align with ACCESS
        // and can be cleared asynchronously by reset.
        in_access_d   = (state_d == ST_ACCESS);
        bus_busy_d    = in_access_d;
        ram_oe_n_d    = !(in_access_d && rw_q);
        ram_we_n_d    = !(in_access_d && !rw_q && (cnt_d != '0) && (cnt_d != CNT_LOAD));
        ram_addr_d    = in_access_d ? addr_q : ram_addr_q;
        ram_wr_data_d = in_access_d ? data_q : ram_wr_data_q;
        pi_done_d     = (state_d == ST_DONE);
    end

    assign ram_addr      = ram_addr_q;
    assign ram_wr_data   = ram_wr_data_q;
    assign ram_oe_n      = ram_oe_n_q;
    assign ram_we_n      = ram_we_n_q;
    assign bus_busy      = bus_busy_q;
    assign pi.pi_done    = pi_done_q;
    assign pi.pi_rd_data = rd_data_q;

endmodule

// File: tb/tb_pi_bus_xfer.sv
// Scoreboard bench for pi_bus_xfer against a behavioural asynchronous-read RAM.
module tb_pi_bus_xfer;
    import pi_bus_xfer_pkg::*;

    localparam int unsigned AC = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              slot_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] ram_rd_data;
    logic              ram_oe_n;
    logic              ram_we_n;
    logic              bus_busy;

    pi_bus_xfer_if pif ();

    pi_bus_xfer #(.ACCESS_CYCLES(AC)) dut (
        .clk         (clk),
        .reset       (reset),
        .pi          (pif.slave),
        .slot_en     (slot_en),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data),
        .ram_oe_n    (ram_oe_n),
        .ram_we_n    (ram_we_n),
        .bus_busy    (bus_busy)
    );

    always #5 clk = ~clk;

    // RAM model: combinational read, write sampled on clk while we_n is low
    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr;
    logic [7:0]        pre_data;

    assign ram_rd_data = ram_oe_n ? 8'h00 : mem[ram_addr];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (!ram_we_n) mem[ram_addr] <= ram_wr_data;
    end

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_rd;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0] exp_wdata;

    // Free-running monitor counters; tests compare differences between snapshots
    int oe_lo = 0, we_lo = 0, we_bad = 0, busy_cy = 0, starts = 0, overlap = 0, done_hi = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (!ram_oe_n) oe_lo++;
            if (!ram_we_n) begin
                we_lo++;
                if (ram_addr !== exp_addr || ram_wr_data !== exp_wdata) we_bad++;
            end
            if (bus_busy) busy_cy++;
            if (bus_busy && !busy_prev) starts++;
            if (bus_busy && pif.pi_done) overlap++;
            if (pif.pi_done) done_hi++;
        end
        busy_prev = bus_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic request(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic rw,
                           input logic [7:0] exp);
        pif.pi_addr    = a;
        pif.pi_data_in = d;
        pif.pi_rw_b    = rw;
        pif.pi_pending = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic pulse_slot();
        slot_en = 1'b1;
        tick(1);
        slot_en = 1'b0;
    endtask

    task automatic wait_level(input logic lvl, input int budget, output bit ok);
        int n = 0;
        while (pif.pi_done !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (pif.pi_done === lvl);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        slot_en = 1'b0;
        pif.pi_pending = 1'b0;
        pif.pi_addr = '0;
        pif.pi_data_in = '0;
        pif.pi_rw_b = 1'b1;
        tick(2);
        checks += 7;
        if (pif.pi_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", pif.pi_done); end
        if (ram_oe_n !== 1'b1) begin failures++; $display("FAIL reset_oe_n got=%b exp=1", ram_oe_n); end
        if (ram_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n got=%b exp=1", ram_we_n); end
        if (bus_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_busy); end
        if (pif.pi_rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", pif.pi_rd_data); end
        if (ram_addr !== '0) begin failures++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
        if (ram_wr_data !== '0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", ram_wr_data); end
        reset = 1'b0;
        exp_rd = 8'h00;
        tick(2);
    endtask

    task automatic test_read();
        int b_oe, b_we, b_busy;
        bit ok;
        b_oe = oe_lo; b_we = we_lo; b_busy = busy_cy;
        request(17'h1_2345, 8'h00, 1'b1, 8'hA5);
        exp_rd = 8'hA5;
        tick(5);
        pulse_slot();
        wait_level(1'b1, 40, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL read_done_timeout got=%b exp=1", pif.pi_done); end
        checks++;
        if (pif.pi_rd_data !== exp_q[0]) begin failures++; $display("FAIL read_data got=%h exp=%h", pif.pi_rd_data, exp_q[0]); end
        void'(exp_q.pop_front());
        checks += 3;
        if (oe_lo - b_oe != AC) begin failures++; $display("FAIL read_oe_cycles got=%0d exp=%0d", oe_lo - b_oe, AC); end
        if (busy_cy - b_busy != AC) begin failures++; $display("FAIL read_busy_cycles got=%0d exp=%0d", busy_cy - b_busy, AC); end
        if (we_lo - b_we != 0) begin failures++; $display("FAIL read_we_cycles got=%0d exp=0", we_lo - b_we); end
        tick(3);
        checks++;
        if (pif.pi_done !== 1'b1) begin failures++; $display("FAIL read_done_held got=%b exp=1", pif.pi_done); end
        pif.pi_pending = 1'b0;
        wait_level(1'b0, 10, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL read_done_fall got=%b exp=0", pif.pi_done); end
        tick(2);
    endtask

    task automatic test_write();
        int b_oe, b_we, b_bad;
        bit ok;
        b_oe = oe_lo; b_we = we_lo; b_bad = we_bad;
        exp_addr = 17'h0_8000;
        exp_wdata = 8'h3C;
        request(17'h0_8000, 8'h3C, 1'b0, exp_rd);
        tick(4);
        pulse_slot();
        wait_level(1'b1, 40, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL write_done_timeout got=%b exp=1", pif.pi_done); end
        checks++;
        if (pif.pi_rd_data !== exp_q[0]) begin failures++; $display("FAIL write_rd_kept got=%h exp=%h", pif.pi_rd_data, exp_q[0]); end
        void'(exp_q.pop_front());
        checks += 4;
        if (we_lo - b_we != 2) begin failures++; $display("FAIL write_we_cycles got=%0d exp=2", we_lo - b_we); end
        if (we_bad - b_bad != 0) begin failures++; $display("FAIL write_bus_value bad_cycles=%0d exp=0", we_bad - b_bad); end
        if (oe_lo - b_oe != 0) begin failures++; $display("FAIL write_oe_cycles got=%0d exp=0", oe_lo - b_oe); end
        if (mem[17'h0_8000] !== 8'h3C) begin failures++; $display("FAIL write_ram got=%h exp=3c", mem[17'h0_8000]); end
        pif.pi_pending = 1'b0;
        wait_level(1'b0, 10, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL write_done_fall got=%b exp=0", pif.pi_done); end
        tick(2);
    endtask

    task automatic test_slot_ignored();
        int b_busy, b_oe, b_we;
        bit ok;
        b_busy = busy_cy; b_oe = oe_lo; b_we = we_lo;
        slot_en = 1'b1;
        tick(3);
        slot_en = 1'b0;
        tick(2);
        checks++;
        if (busy_cy - b_busy + oe_lo - b_oe + we_lo - b_we != 0) begin
            failures++;
            $display("FAIL idle_slot_activity busy=%0d oe=%0d we=%0d exp=0", busy_cy - b_busy, oe_lo - b_oe, we_lo - b_we);
        end
        request(17'h0_0010, 8'h00, 1'b1, 8'h5A);
        exp_rd = 8'h5A;
        tick(4);
        pulse_slot();
        wait_level(1'b1, 40, ok);
        checks++;
        if (pif.pi_rd_data !== exp_q[0] || !ok) begin failures++; $display("FAIL slot_read got=%h exp=%h", pif.pi_rd_data, exp_q[0]); end
        void'(exp_q.pop_front());
        b_busy = busy_cy; b_oe = oe_lo; b_we = we_lo;
        slot_en = 1'b1;
        tick(4);
        slot_en = 1'b0;
        checks += 2;
        if (busy_cy - b_busy + oe_lo - b_oe + we_lo - b_we != 0) begin
            failures++;
            $display("FAIL done_slot_activity busy=%0d oe=%0d we=%0d exp=0", busy_cy - b_busy, oe_lo - b_oe, we_lo - b_we);
        end
        if (pif.pi_done !== 1'b1) begin failures++; $display("FAIL done_slot_held got=%b exp=1", pif.pi_done); end
        pif.pi_pending = 1'b0;
        wait_level(1'b0, 10, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL slot_done_fall got=%b exp=0", pif.pi_done); end
        tick(2);
    endtask

    task automatic test_drop_in_wait();
        int b_oe, b_done;
        bit ok;
        b_oe = oe_lo; b_done = done_hi;
        request(17'h1_2345, 8'h00, 1'b1, 8'hA5);
        exp_rd = 8'hA5;
        tick(5);
        pif.pi_pending = 1'b0;
        tick(4);
        pulse_slot();
        wait_level(1'b1, 40, ok);
        checks++;
        if (pif.pi_rd_data !== exp_q[0] || !ok) begin failures++; $display("FAIL drop_read got=%h done=%b exp=%h", pif.pi_rd_data, pif.pi_done, exp_q[0]); end
        void'(exp_q.pop_front());
        tick(4);
        checks += 2;
        if (done_hi - b_done != 1) begin failures++; $display("FAIL drop_done_len got=%0d exp=1", done_hi - b_done); end
        if (oe_lo - b_oe != AC) begin failures++; $display("FAIL drop_oe_cycles got=%0d exp=%0d", oe_lo - b_oe, AC); end
    endtask

    task automatic test_reset_mid_access();
        int n;
        preload(17'h0_0100, 8'h11);
        exp_addr = 17'h0_0100;
        exp_wdata = 8'h77;
        request(17'h0_0100, 8'h77, 1'b0, exp_rd);
        tick(4);
        slot_en = 1'b1;
        n = 0;
        while (bus_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        slot_en = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_we_n !== 1'b0) begin failures++; $display("FAIL mid_we_cycle2 got=%b exp=0", ram_we_n); end
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (ram_we_n !== 1'b1) begin failures++; $display("FAIL rst_we_n got=%b exp=1", ram_we_n); end
        if (ram_oe_n !== 1'b1) begin failures++; $display("FAIL rst_oe_n got=%b exp=1", ram_oe_n); end
        if (pif.pi_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", pif.pi_done); end
        if (bus_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus_busy); end
        exp_q.delete();
        pif.pi_pending = 1'b0;
        tick(2);
        checks += 2;
        if (mem[17'h0_0100] !== 8'h11) begin failures++; $display("FAIL rst_ram_kept got=%h exp=11", mem[17'h0_0100]); end
        if (ram_addr !== '0) begin failures++; $display("FAIL rst_ram_addr got=%h exp=0", ram_addr); end
        reset = 1'b0;
        exp_rd = 8'h00;
        tick(2);
        checks++;
        if (pif.pi_rd_data !== exp_rd) begin failures++; $display("FAIL rst_rd_data got=%h exp=%h", pif.pi_rd_data, exp_rd); end
    endtask

    task automatic test_back_to_back();
        int b_starts, b_ovl, n;
        bit ok;
        b_starts = starts; b_ovl = overlap;
        slot_en = 1'b1;
        request(17'h0_0010, 8'h00, 1'b1, 8'h5A);
        exp_rd = 8'h5A;
        wait_level(1'b1, 40, ok);
        checks++;
        if (pif.pi_rd_data !== exp_q[0] || !ok) begin failures++; $display("FAIL b2b_first got=%h done=%b exp=%h", pif.pi_rd_data, pif.pi_done, exp_q[0]); end
        void'(exp_q.pop_front());
        pif.pi_pending = 1'b0;
        wait_level(1'b0, 10, ok);
        exp_addr = 17'h0_0020;
        exp_wdata = 8'hC3;
        request(17'h0_0020, 8'hC3, 1'b0, exp_rd);
        n = 0;
        while (bus_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n != 4) begin failures++; $display("FAIL b2b_restart_latency got=%0d exp=4", n); end
        wait_level(1'b1, 40, ok);
        checks++;
        if (pif.pi_rd_data !== exp_q[0] || !ok) begin failures++; $display("FAIL b2b_second got=%h done=%b exp=%h", pif.pi_rd_data, pif.pi_done, exp_q[0]); end
        void'(exp_q.pop_front());
        pif.pi_pending = 1'b0;
        wait_level(1'b0, 10, ok);
        slot_en = 1'b0;
        tick(2);
        checks += 3;
        if (starts - b_starts != 2) begin failures++; $display("FAIL b2b_accesses got=%0d exp=2", starts - b_starts); end
        if (overlap - b_ovl != 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=0", overlap - b_ovl); end
        if (mem[17'h0_0020] !== 8'hC3) begin failures++; $display("FAIL b2b_ram got=%h exp=c3", mem[17'h0_0020]); end
    endtask

    initial begin
        test_reset();
        preload(17'h1_2345, 8'hA5);
        preload(17'h0_8000, 8'h00);
        preload(17'h0_0010, 8'h5A);
        preload(17'h0_0020, 8'h00);
        test_read();
        test_write();
        test_slot_ignored();
        test_drop_in_wait();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pi_bus_xfer.md
PI_BUS_XFER -- requirements
Module: pi_bus_xfer

Interface
REQ-001 Parameter ACCESS_CYCLES, default 4, length of one RAM access in clk cycles; legal range 3..15.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 pi_pending  in  1  request flag from the SPI-domain command decoder; asynchronous to clk.
REQ-005 pi_addr  in  17  target address; stable from pi_pending rise until pi_done rise.
REQ-006 pi_data_in  in  8  write data; stable over the same interval as pi_addr.
REQ-007 pi_rw_b  in  1  1 = read, 0 = write; stable over the same interval as pi_addr.
REQ-008 pi_done  out  1  completion flag returned to the SPI-domain decoder.
REQ-009 pi_rd_data  out  8  read result; valid while pi_done = 1 after a read.
REQ-010 slot_en  in  1  one-clk strobe from the timing generator marking a free bus slot.
REQ-011 ram_addr  out  17  RAM address.
REQ-012 ram_wr_data  out  8  RAM write data.
REQ-013 ram_rd_data  in  8  RAM read data.
REQ-014 ram_oe_n  out  1  RAM output enable, active low.
REQ-015 ram_we_n  out  1  RAM write enable, active low.
REQ-016 bus_busy  out  1  high while this block owns the RAM bus.

Function
REQ-017 pi_pending shall pass through a 2-flop synchronizer; only the synchronized copy (pend_s) is used.
REQ-018 States: IDLE, WAIT_SLOT, ACCESS, DONE.
REQ-019 IDLE -> WAIT_SLOT when pend_s = 1; pi_addr, pi_data_in and pi_rw_b are registered on that edge.
REQ-020 WAIT_SLOT -> ACCESS on the first clk where slot_en = 1; slot_en is ignored in every other state.
REQ-021 ACCESS lasts exactly ACCESS_CYCLES clks, tracked by a 4-bit down-counter; bus_busy = 1 throughout ACCESS only.
REQ-022 In ACCESS, ram_addr = registered address and ram_wr_data = registered data; outside ACCESS both hold their last value.
REQ-023 Read: ram_oe_n = 0 for all ACCESS cycles; ram_we_n = 1.
REQ-024 Write: ram_we_n = 0 on ACCESS cycles 2..ACCESS_CYCLES-1 (1-based; first and last cycles give setup/hold); ram_oe_n = 1.
REQ-025 Read: ram_rd_data is registered into pi_rd_data on the last ACCESS cycle; pi_rd_data is unchanged by writes.
REQ-026 ACCESS -> DONE after the last cycle; pi_done = 1 (registered) for the whole of DONE.
REQ-027 DONE -> IDLE when pend_s = 0; pi_done falls on that same edge.
REQ-028 A new request is not accepted until one clk after returning to IDLE (pend_s must be observed high in IDLE).
REQ-029 pend_s dropping in WAIT_SLOT or ACCESS (protocol violation) does not abort the access; the transfer completes, and DONE lasts one clk.
REQ-030 Latency: pi_pending rise to ACCESS start = 3 clks + wait for slot_en; ACCESS start to pi_done = ACCESS_CYCLES clks.

Reset
REQ-031 On reset, asynchronously: state = IDLE, pi_done = 0, ram_oe_n = 1, ram_we_n = 1, bus_busy = 0, pi_rd_data = 0, ram_addr = 0, ram_wr_data = 0, synchronizer flops = 0.
REQ-032 Reset asserted mid-ACCESS releases the bus (oe_n/we_n = 1) immediately without waiting for clk.

Structure
REQ-033 State encoding and the ADDR_W = 17 / DATA_W = 8 constants belong in the shared PET package.
REQ-034 The 2-flop synchronizer is a separate sub-module, sync2, reusable across clock-domain crossings.

Verification
REQ-035 Read: RAM[0x1_2345] = 0xA5, pi_rw_b = 1, raise pending, slot_en after 5 clks -> ram_oe_n low 4 clks, pi_rd_data = 0xA5, pi_done = 1 until pending drops.
REQ-036 Write: addr 0x0_8000, data 0x3C, pi_rw_b = 0 -> ram_we_n low exactly 2 clks with ram_addr = 0x08000 and ram_wr_data = 0x3C; RAM[0x08000] = 0x3C afterwards.
REQ-037 slot_en pulsed in IDLE and in DONE -> no bus activity; bus_busy stays 0.
REQ-038 Reset in ACCESS cycle 2 of a write -> ram_we_n = 1 and pi_done = 0 within 1 ns, state IDLE; RAM location unchanged.
REQ-039 pending dropped during WAIT_SLOT -> access still completes on next slot_en, pi_done high for exactly 1 clk.
REQ-040 Back-to-back: second pending rise right after pi_done falls -> second access starts only after the IDLE re-observation; two complete, non-overlapping handshakes.
